// File: rtl/tree_operand_pairer.sv
// rtl/tree_operand_pairer.sv - operand pairer feeding one binary-tree adder level
//
// Purpose: groups a serial operand stream into (A, B) pairs for the
// carry-lookahead adder stage. Odd groups are closed with a zero-padded B.
// It also delays a valid/last tag and the per-group pair count to line up
// with the adder's Sum output.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   in_*          operand stream (valid/ready, data, last)
//   pair_a/b      registered adder operands
//   pair_valid    pair registers hold an unissued pair
//   pair_last     pair contains the group's final operand
//   out_ready     next level takes the current pair's result this cycle
//   sum_valid     adder Sum is a real result this cycle
//   sum_last      that result closes its group
//   group_pairs   pairs in the group, meaningful when sum_last=1
module tree_operand_pairer #(
  parameter int W   = 17,
  parameter int LAT = 1,
  parameter int CW  = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic          in_last,
  output logic [W-1:0]  pair_a,
  output logic [W-1:0]  pair_b,
  output logic          pair_valid,
  output logic          pair_last,
  input  logic          out_ready,
  output logic          sum_valid,
  output logic          sum_last,
  output logic [CW-1:0] group_pairs
);

  typedef enum logic {EMPTY = 1'b0, HALF = 1'b1} state_t;

  state_t        state;
  state_t        state_next;
  logic [W-1:0]  hold_a;
  logic          accept;
  logic          fire;
  logic          load;
  logic          hold_en;
  logic [W-1:0]  load_a;
  logic [W-1:0]  load_b;
  logic          load_last;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic          tag_v    [LAT];
  logic          tag_l    [LAT];
  logic [CW-1:0] cnt_pipe [LAT];

  // A pending pair can be replaced in the same cycle it fires.
  assign in_ready = !pair_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign fire     = pair_valid && out_ready;
  assign cnt_inc  = (cnt == {CW{1'b1}}) ? cnt : cnt + 1'b1;

  always_comb begin
    state_next = state;
    load       = 1'b0;
    hold_en    = 1'b0;
    load_a     = in_data;
    load_b     = '0;
    load_last  = 1'b1;
    case (state)
      EMPTY: begin
        if (accept) begin
          if (in_last) begin
            load = 1'b1;          // odd singleton closes the group, B padded with 0
          end else begin
            hold_en    = 1'b1;
            state_next = HALF;
          end
        end
      end
      HALF: begin
        if (accept) begin
          load       = 1'b1;
          load_a     = hold_a;
          load_b     = in_data;
          load_last  = in_last;
          state_next = EMPTY;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      hold_a     <= '0;
      pair_a     <= '0;
      pair_b     <= '0;
      pair_valid <= 1'b0;
      pair_last  <= 1'b0;
      cnt        <= '0;
      for (int i = 0; i < LAT; i++) begin
        tag_v[i]    <= 1'b0;
        tag_l[i]    <= 1'b0;
        cnt_pipe[i] <= '0;
      end
    end else begin
      state <= state_next;
      if (hold_en) begin
        hold_a <= in_data;
      end

      // Load wins over fire; on a bare fire the operands stay put so the
      // adder keeps sampling a stable value.
      if (load) begin
        pair_valid <= 1'b1;
        pair_a     <= load_a;
        pair_b     <= load_b;
        pair_last  <= load_last;
      end else if (fire) begin
        pair_valid <= 1'b0;
      end

      if (fire) begin
        cnt <= pair_last ? '0 : cnt_inc;
      end

      // Tag and count pipes advance every cycle to track the adder latency.
      tag_v[0]    <= fire;
      tag_l[0]    <= fire && pair_last;
      cnt_pipe[0] <= (fire && pair_last) ? cnt_inc : cnt_pipe[0];
      for (int i = 1; i < LAT; i++) begin
        tag_v[i]    <= tag_v[i-1];
        tag_l[i]    <= tag_l[i-1];
        cnt_pipe[i] <= cnt_pipe[i-1];
      end
    end
  end

  assign sum_valid   = tag_v[LAT-1];
  assign sum_last    = tag_l[LAT-1];
  assign group_pairs = cnt_pipe[LAT-1];

endmodule

// File: tb/tb_tree_operand_pairer.sv
// tb/tb_tree_operand_pairer.sv - randomized self-checking bench for tree_operand_pairer
module tb_tree_operand_pairer;

  localparam int W   = 17;
  localparam int LAT = 2;
  localparam int CW  = 8;
  localparam int GP_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          in_last = 1'b0;
  logic [W-1:0]  pair_a;
  logic [W-1:0]  pair_b;
  logic          pair_valid;
  logic          pair_last;
  logic          out_ready = 1'b1;
  logic          sum_valid;
  logic          sum_last;
  logic [CW-1:0] group_pairs;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int mode  = 0;   // 0: out_ready=1, 1: random, 2: out_ready=0

  tree_operand_pairer #(.W(W), .LAT(LAT), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .pair_a(pair_a), .pair_b(pair_b), .pair_valid(pair_valid), .pair_last(pair_last),
    .out_ready(out_ready), .sum_valid(sum_valid), .sum_last(sum_last),
    .group_pairs(group_pairs)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural adder stage: samples its inputs every edge, Sum after LAT edges.
  logic [W:0] add_pipe [LAT];
  always @(posedge clk) begin
    add_pipe[0] <= {1'b0, pair_a} + {1'b0, pair_b};
    for (int i = 1; i < LAT; i++) add_pipe[i] <= add_pipe[i-1];
  end

  always begin
    @(posedge clk);
    #1;
    case (mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  // Reference model: operands of the open group, expected pairs, in-flight results.
  typedef struct { logic [W-1:0] a; logic [W-1:0] b; logic last; int gp; } pair_t;
  typedef struct { logic [W:0] sum; logic last; int gp; int cyc; } flt_t;
  logic [W-1:0] ops [$];
  pair_t        pq  [$];
  flt_t         fq  [$];
  int           grp_pairs = 0;
  logic [W:0]   last_sum = '0;
  pair_t        mp;
  flt_t         mf;

  always @(negedge clk) begin
    cyc++;
    if (sum_valid) begin
      if (fq.size() == 0) begin
        check("sum_spurious", 32'(sum_valid), 32'd0);
      end else begin
        mf = fq.pop_front();
        last_sum = add_pipe[LAT-1];
        check("sum_cycle", 32'(cyc), 32'(mf.cyc + LAT));
        check("sum", 32'(add_pipe[LAT-1]), 32'(mf.sum));
        check("sum_last", 32'(sum_last), 32'(mf.last));
        if (mf.last) check("group_pairs", 32'(group_pairs), 32'(mf.gp));
      end
    end
    if (rst) begin
      ops.delete();
      pq.delete();
      fq.delete();
      grp_pairs = 0;
    end else begin
      if (pair_valid && out_ready) begin
        if (pq.size() == 0) begin
          check("fire_unexpected", 32'd1, 32'd0);
        end else begin
          mp = pq.pop_front();
          check("pair_a", 32'(pair_a), 32'(mp.a));
          check("pair_b", 32'(pair_b), 32'(mp.b));
          check("pair_last", 32'(pair_last), 32'(mp.last));
          mf.sum  = {1'b0, mp.a} + {1'b0, mp.b};
          mf.last = mp.last;
          mf.gp   = mp.gp;
          mf.cyc  = cyc;
          fq.push_back(mf);
        end
      end
      if (in_valid && in_ready) begin
        ops.push_back(in_data);
        if (ops.size() == 2 || in_last) begin
          grp_pairs++;
          mp.a    = ops[0];
          mp.b    = (ops.size() == 2) ? ops[1] : '0;
          mp.last = in_last;
          mp.gp   = (grp_pairs > GP_MAX) ? GP_MAX : grp_pairs;
          pq.push_back(mp);
          ops.delete();
          if (in_last) grp_pairs = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d, input logic last);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (n == 200) check("send_timeout", 32'd0, 32'd1);
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    for (n = 0; n < 400; n++) begin
      @(negedge clk);
      if (pq.size() == 0 && fq.size() == 0) break;
    end
    step();
    check(tag, 32'(pq.size() + fq.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int gsz;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_pair_valid", 32'(pair_valid), 32'd0);
    check("rst_pair_a", 32'(pair_a), 32'd0);
    check("rst_sum_valid", 32'(sum_valid), 32'd0);
    check("rst_group_pairs", 32'(group_pairs), 32'd0);
    step();

    send(17'd5, 1'b0); send(17'd7, 1'b0); send(17'd9, 1'b0); send(17'd11, 1'b1);
    drain("drain_even4");
    check("gp_even4", 32'(group_pairs), 32'd2);

    send(17'd1, 1'b0); send(17'd2, 1'b0); send(17'd3, 1'b1);
    drain("drain_odd3");
    check("gp_odd3", 32'(group_pairs), 32'd2);

    send(17'h00ABC, 1'b1);
    drain("drain_single");
    check("gp_single", 32'(group_pairs), 32'd1);

    mode = 2;
    step();
    send(17'd4, 1'b0); send(17'd6, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_pair_a", 32'(pair_a), 32'd4);
      check("bp_pair_b", 32'(pair_b), 32'd6);
      check("bp_sum_valid", 32'(sum_valid), 32'd0);
    end
    step();
    mode = 0;
    drain("drain_bp");
    check("bp_sum", 32'(last_sum), 32'd10);

    send(17'd8, 1'b0);
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    check("midrst_pair_valid", 32'(pair_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    send(17'd2, 1'b0); send(17'd3, 1'b1);
    drain("drain_midrst");
    check("midrst_sum", 32'(last_sum), 32'd5);

    send(17'h1FFFF, 1'b0); send(17'h1FFFF, 1'b1);
    drain("drain_carry");
    check("carry_sum", 32'(last_sum), 32'h3FFFE);

    mode = 1;
    for (int g = 0; g < 40; g++) begin
      gsz = $urandom_range(1, 6);
      for (int k = 0; k < gsz; k++) begin
        if ($urandom_range(0, 4) == 0) begin
          in_last = 1'b1;      // last without valid must be ignored
          step();
          in_last = 1'b0;
        end
        send(17'($urandom), (k == gsz - 1) ? 1'b1 : 1'b0);
      end
    end
    step();
    mode = 0;
    drain("drain_random");

    for (int k = 0; k < 520; k++) send(17'($urandom), (k == 519) ? 1'b1 : 1'b0);
    drain("drain_sat");
    check("gp_saturate", 32'(group_pairs), 32'(GP_MAX));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tree_operand_pairer.md
# tree_operand_pairer

Upstream feeder for one level of the multi-operand binary-tree adder. It accepts a serial stream of W-bit operands with a valid/ready handshake, groups consecutive operands into (A, B) pairs, and presents each pair in registers to the 17-bit carry-lookahead adder stage. The adder registers its inputs on every clock edge. This block also carries a valid/last tag alongside each issued pair, delayed to match the adder latency, so the next tree level knows which Sum words are real and where a group ends.

## Interface
Parameters:
- W, 17: operand width; equals the adder operand width.
- LAT, 1: adder latency in cycles, from the sampling edge to a valid Sum; minimum 1.
- CW, 8: width of the per-group pair counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand present.
- in_ready  out  1  block can accept an operand this cycle.
- in_data  in  W  operand value.
- in_last  in  1  marks the final operand of a group.
- pair_a  out  W  adder A input, registered.
- pair_b  out  W  adder B input, registered.
- pair_valid  out  1  pair_a/pair_b hold an unissued pair.
- pair_last  out  1  the pair contains the group's final operand.
- out_ready  in  1  next level accepts the adder result of the current pair this cycle.
- sum_valid  out  1  adder Sum output is a real result this cycle.
- sum_last  out  1  that result closes the group.
- group_pairs  out  CW  number of pairs in the group, valid when sum_last is 1.

The adder carry-in is tied 0 externally.

## Operation
- Accept condition: in_valid & in_ready, with in_ready = !pair_valid | out_ready (combinational).
- Fire condition: pair_valid & out_ready.
- The pairing FSM has two states:
  - EMPTY: no operand held.
  - HALF: operand held in hold_a.
- EMPTY, accept, in_last=0: hold_a <= in_data; next state HALF.
- EMPTY, accept, in_last=1: odd singleton; load pair (in_data, 0) with pair_last=1; stay EMPTY.
- HALF, accept: load pair (hold_a, in_data) with pair_last=in_last; next state EMPTY.
- An in_last=1 in HALF therefore closes an even group. A group of 2k+1 operands issues k+1 pairs, the last one zero-padded in B.
- Pair register priority:
  - A load sets pair_valid=1 and overwrites pair_a, pair_b and pair_last.
  - Otherwise, if the pair fires, pair_valid clears and pair_a, pair_b and pair_last hold their values.
  - Load and fire in the same cycle are legal (back-to-back throughput).
- Tag pipeline is a LAT-deep shift register that advances every cycle, independent of out_ready:
  - Stage 0 captures (fire, pair_last & fire).
  - sum_valid and sum_last are taken from stage LAT-1.
- Pair counter:
  - cnt increments on each fire, saturating at 2^CW-1.
  - On a fire with pair_last=1, the counter value including this pair is pushed into a LAT-deep count pipe, and cnt resets to 0.
  - group_pairs is taken from that pipe's last stage; it holds its value between groups.
- Width rule: the block performs no arithmetic on data. The W+1-bit Sum width growth is handled by the adder and the next level.

## Timing
- Reset (rst=1 at an edge) sets:
  - state to EMPTY; hold_a, pair_a and pair_b to 0;
  - pair_valid, pair_last, sum_valid, sum_last to 0;
  - group_pairs and cnt to 0; all tag and count pipe stages to 0.
- in_ready is 1 in the cycle after reset.
- Reset mid-group discards the held operand and any unissued pair. In-flight tags are cleared, so no sum_valid appears for pre-reset pairs.
- Latency:
  - An operand accepted at edge N that completes a pair gives pair_valid=1 in cycle N+1.
  - A fire at edge E means the adder samples the pair at E; sum_valid=1 in cycle E+LAT, aligned with the Sum that results from that sampling.
- Throughput: one operand per cycle while out_ready=1, which gives one pair every 2 cycles, or every cycle for singleton groups.
- Backpressure:
  - While out_ready=0 and pair_valid=1, in_ready=0 and the pair registers are stable.
  - The adder keeps re-sampling the same pair, but no tag is generated.
- in_last=1 with in_valid=0 has no effect.

## Test plan
- Operands 5, 7, 9, 11 (in_last on 11), out_ready=1: pairs (5,7) then (9,11,last); sum_valid on Sum=12 then Sum=20 with sum_last=1; group_pairs=2.
- Operands 1, 2, 3 (last on 3): pairs (1,2) and (3,0,last); Sums 3 and 3; group_pairs=2; state EMPTY afterwards.
- Single operand 0x00ABC with in_last: pair (0x00ABC,0,last) one cycle later; sum_last=1; group_pairs=1.
- Pair (4,6) pending with out_ready=0 for 3 cycles: in_ready=0, pair_a=4 and pair_b=6 held, sum_valid stays 0; on release, exactly one sum_valid with Sum=10.
- rst pulsed while in HALF holding 8, then operands 2, 3 (last): pair is (2,3), not (8,2); no stale sum_valid.
- Operands 0x1FFFF, 0x1FFFF (last): Sum=0x3FFFE with Carry (bit 17)=1, sum_last=1.
